// File: rtl/pipe_ex_muldiv_pkg.sv
// Shared CPU package for the EX-stage multiply/divide unit.
// Holds the op encodings decoded by the ID control unit, the muldiv FSM
// state encoding, the divider iteration count and small helper functions.
package pipe_ex_muldiv_pkg;

  // Operation select carried from ID into EX (op[1]: divide, op[0]: signed).
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MUL   = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Muldiv FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Restoring divider: one quotient bit per iteration.
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  function automatic logic op_is_signed(input logic [1:0] o);
    return o[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div32.sv
// Radix-2 restoring divider datapath for unsigned 32-bit magnitudes.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture dividend/divisor and clear the iteration count
//   step       - perform one restoring iteration (one quotient bit)
//   dividend   - unsigned dividend magnitude
//   divisor    - unsigned divisor magnitude (nonzero when stepped)
//   quotient   - quotient shift register (valid after DIV_ITERS steps)
//   remainder  - partial remainder (valid after DIV_ITERS steps)
//   last       - high while the step about to be taken is the final one
module muldiv_div32
  import pipe_ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fits;

  // The dividend is shifted out of the quotient register MSB-first into the
  // remainder while quotient bits are shifted in from the bottom. Because the
  // partial remainder stays below the divisor, the shifted value is below
  // twice the divisor, so bit 32 of the trial difference is a clean borrow.
  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    fits    = ~trial[32];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= fits ? trial[31:0] : shifted[31:0];
      quo_q <= {quo_q[30:0], fits};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CNT_W'(DIV_ITERS - 1));

endmodule

// File: rtl/pipe_ex_muldiv.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start, op       - request from EX; op = MULTU/MUL/DIVU/DIV
//   a, b            - rs/rt operands after forwarding, sampled on acceptance
//   w_hi, w_lo      - MTHI/MTLO strobes (honoured only when idle)
//   wdata           - MTHI/MTLO data
//   flush           - abandon any in-flight operation
//   busy            - unit occupied (ID folds this into its stall)
//   done            - one-cycle pulse when a new HI/LO result lands
//   hi, lo          - HI/LO registers
module pipe_ex_muldiv
  import pipe_ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        w_hi,
  input  logic        w_lo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]  state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;

  logic        accept;
  logic        div_load;
  logic        div_step;
  logic        div_last;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign busy   = (state != ST_IDLE);
  assign accept = (state == ST_IDLE) && start && !flush;

  // The divider captures magnitudes straight from the ports on the accept
  // edge, in parallel with the operand latch, so it can iterate next cycle.
  assign div_load = accept && op_is_div(op);
  assign div_step = (state == ST_DIV) && !flush;

  muldiv_div32 u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag32(a, op_is_signed(op))),
    .divisor   (mag32(b, op_is_signed(op))),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  // Single-cycle multiplier: extend both operands to 64 bits (sign or zero)
  // and keep the low 64 bits, which is the exact product in both cases.
  always_comb begin
    a_ext   = op_is_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext   = op_is_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    product = a_ext * b_ext;
  end

  // Sign fix-up and divide-by-zero result. Quotient is negative iff the
  // operand signs differ; remainder follows the dividend. The most-negative
  // by minus-one case needs no special path: its unsigned quotient
  // 0x80000000 is left un-negated because both signs are set.
  always_comb begin
    fix_hi = div_rem;
    fix_lo = div_quo;
    if (b_q == 32'd0) begin
      fix_hi = a_q;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      if (op_is_signed(op_q) && (a_q[31] ^ b_q[31])) fix_lo = ~div_quo + 32'd1;
      if (op_is_signed(op_q) && a_q[31])             fix_hi = ~div_rem + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            if (!op_is_div(op))    state <= ST_MUL;
            else if (b == 32'd0)   state <= ST_FIX;
            else                   state <= ST_DIV;
          end else begin
            if (w_hi) hi <= wdata;
            if (w_lo) lo <= wdata;
          end
        end
        ST_MUL: begin
          hi    <= product[63:32];
          lo    <= product[31:0];
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_DIV: begin
          if (div_last) state <= ST_FIX;
        end
        default: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ex_muldiv.sv
// Self-checking bench for pipe_ex_muldiv: a scoreboard queue fed by the
// stimulus thread and drained by a monitor on every done pulse.
module tb_pipe_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        w_hi;
  logic        w_lo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  pipe_ex_muldiv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .w_hi  (w_hi),
    .w_lo  (w_lo),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // cyc = index of the current cycle; the cycle driven at cyc=T is sampled
  // at the edge closing it, and its result is due in cycle T+latency.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the architectural definition: {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy;
    int     ix, iy;
    logic [63:0] r;
    case (o)
      2'b00: r = {32'd0, x} * {32'd0, y};
      2'b01: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = 64'(sx * sy);
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (o == 2'b10) r = {x % y, x / y};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          ix = int'(x);
          iy = int'(y);
          r  = {32'(ix % iy), 32'(ix / iy)};
        end
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] y);
    return (o[1] && y != 32'd0) ? 34 : 2;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      check("done_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("result_hi", 64'(hi), 64'(e.hi));
        check("result_lo", 64'(lo), 64'(e.lo));
        check("result_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drives one start request; returns with the bench in cycle T+1.
  // With mv set, a conflicting MTHI+MTLO is presented in the same cycle.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit expect_result, input bit mv, output int t);
    logic [63:0] r;
    exp_t        e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    w_hi  = mv;
    w_lo  = mv;
    wdata = $urandom;
    t     = cyc;
    if (expect_result) begin
      r     = ref_result(o, x, y);
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.cyc = t + ref_latency(o, y);
      sb_q.push_back(e);
      model_hi = r[63:32];
      model_lo = r[31:0];
    end
    @(negedge clk);
    start = 1'b0;
    w_hi  = 1'b0;
    w_lo  = 1'b0;
    // Scramble operands while busy; the result must not depend on them.
    a  = $urandom;
    b  = $urandom;
    op = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int          t;
    logic [31:0] prev_lo;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    w_hi = 1'b0; w_lo = 1'b0; wdata = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    // MTHI alone, then MTHI+MTLO together.
    @(negedge clk);
    w_hi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    w_hi = 1'b0;
    model_hi = 32'h1234_5678;
    check("mthi_hi", 64'(hi), 64'(model_hi));
    check("mthi_lo", 64'(lo), 64'(model_lo));
    w_hi = 1'b1; w_lo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    w_hi = 1'b0; w_lo = 1'b0;
    model_hi = 32'hCAFE_F00D; model_lo = 32'hCAFE_F00D;
    check("mthilo_hi", 64'(hi), 64'(model_hi));
    check("mthilo_lo", 64'(lo), 64'(model_lo));
    check("mthilo_no_done", 64'(done), 64'd0);

    // Signed multiply -2 * 3: busy only in T+1.
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, t);
    check("mul_busy_t1", 64'(busy), 64'd1);
    @(negedge clk);
    check("mul_busy_t2", 64'(busy), 64'd0);

    // Unsigned multiply of all-ones.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, t);
    wait_idle();

    // Signed divide -7 / 2, re-issued start and MTLO while busy are ignored.
    prev_lo = model_lo;
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, t);
    check("div_busy_t1", 64'(busy), 64'd1);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    w_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; w_lo = 1'b0;
    check("mtlo_while_busy", 64'(lo), 64'(prev_lo));
    repeat (22) @(negedge clk);
    check("div_busy_t33", 64'(busy), 64'd1);
    @(negedge clk);
    check("div_busy_t34", 64'(busy), 64'd0);

    // Divide by zero, then the most-negative by minus-one case.
    issue(2'b10, 32'd100, 32'd0, 1'b1, 1'b0, t);
    wait_idle();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, t);
    wait_idle();

    // Start and move in the same idle cycle: start wins.
    issue(2'b01, 32'd3, 32'hFFFF_FFFB, 1'b1, 1'b1, t);
    wait_idle();

    // Flush mid-divide at T+5.
    issue(2'b10, 32'h0BAD_F00D, 32'd13, 1'b0, 1'b0, t);
    repeat (4) @(negedge clk);
    flush = 1'b1; start = 1'b1; w_hi = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0; w_hi = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'(model_hi));
    check("flush_lo", 64'(lo), 64'(model_lo));
    repeat (40) @(negedge clk);
    check("flush_hi_later", 64'(hi), 64'(model_hi));

    // Flush in idle suppresses a same-cycle start and move.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 2'b00; w_hi = 1'b1; wdata = 32'h5555_AAAA;
    @(negedge clk);
    flush = 1'b0; start = 1'b0; w_hi = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_idle_hi", 64'(hi), 64'(model_hi));

    // Reset mid-divide at T+5.
    issue(2'b11, 32'hF000_0001, 32'd7, 1'b0, 1'b0, t);
    repeat (4) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    model_hi = '0; model_lo = '0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(ro, ra, rb, 1'b1, ($urandom_range(0, 3) == 0), t);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("final_hi", 64'(hi), 64'(model_hi));
    check("final_lo", 64'(lo), 64'(model_lo));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ex_muldiv.md
PIPE_EX_MULDIV -- requirements
Module: pipe_ex_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a multiply/divide from EX.
REQ-004 SHALL have port op, input, 2 bits: operation select; 00 MULTU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
REQ-005 SHALL have port a, input, 32 bits: rs operand, post-forwarding.
REQ-006 SHALL have port b, input, 32 bits: rt operand, post-forwarding.
REQ-007 SHALL have port w_hi, input, 1 bit: MTHI write strobe.
REQ-008 SHALL have port w_lo, input, 1 bit: MTLO write strobe.
REQ-009 SHALL have port wdata, input, 32 bits: MTHI/MTLO data.
REQ-010 SHALL have port flush, input, 1 bit: cancel any in-flight operation.
REQ-011 SHALL have port busy, output, 1 bit: unit occupied; ID ORs it into stall.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking a new hi/lo result.
REQ-013 SHALL have port hi, output, 32 bits: HI register.
REQ-014 SHALL have port lo, output, 32 bits: LO register.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIX; busy = (state != IDLE), combinational from state.
REQ-016 SHALL accept start only in IDLE; at that edge, latch a, b, op and go to MUL (op[1]=0), DIV (op[1]=1, b!=0) or FIX (op[1]=1, b==0).
REQ-017 SHALL ignore start while busy, with no effect on state, operands or hi/lo.
REQ-018 MUL SHALL last one cycle; at its end hi:lo <= 64-bit product (signed for op=01, unsigned for op=00); go to IDLE.
REQ-019 DIV SHALL run 32 radix-2 restoring iterations on magnitudes (|a|, |b| when op=11), one quotient bit per cycle, then go to FIX.
REQ-020 FIX SHALL last one cycle and write lo <= quotient, hi <= remainder; go to IDLE.
REQ-021 For signed divide, quotient SHALL be negated iff a[31]^b[31], and remainder SHALL take the sign of a.
REQ-022 0x80000000 DIV 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, with no trap.
REQ-023 Divide by zero (either op) SHALL give lo=0xFFFFFFFF, hi=a.
REQ-024 Latency, start sampled at edge T: MUL completes with new hi/lo and done=1 in cycle T+2; DIV in T+34; divide-by-zero in T+2.
REQ-025 done SHALL be registered, high for exactly the first IDLE cycle after a completed operation, else 0.
REQ-026 w_hi/w_lo in IDLE SHALL write wdata to hi/lo at the next edge; both together write both.
REQ-027 w_hi/w_lo while busy SHALL be ignored.
REQ-028 start and w_hi/w_lo in the same IDLE cycle: start SHALL win and the move is dropped.
REQ-029 flush SHALL force IDLE at the next edge: hi/lo unchanged, done=0, any same-cycle start/w_hi/w_lo ignored.
REQ-030 Operands SHALL be sampled only at acceptance; a/b changes while busy SHALL not affect the result.

Reset
REQ-031 rst=1 at an edge SHALL set state=IDLE, hi=0, lo=0, done=0, and clear operand/iteration registers; busy=0 the following cycle.
REQ-032 rst SHALL take priority over flush, start and w_hi/w_lo, including mid-divide: the result is discarded and no done pulse is issued.

Structure
REQ-033 Op encodings (MULTU/MUL/DIVU/DIV), FSM state encoding and divider iteration count (32) SHALL live in the shared CPU package used by the ID control unit.
REQ-034 The divider datapath (remainder/quotient shift registers, 6-bit iteration counter, subtract/restore step) SHALL be one sub-module, muldiv_div32; FSM, multiplier and hi/lo SHALL stay in pipe_ex_muldiv.

Verification
REQ-035 MUL a=0xFFFFFFFE (-2), b=3 -> T+2: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1; busy=1 only in T+1.
REQ-036 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 DIV a=-7, b=2 -> busy T+1..T+33; T+34: lo=0xFFFFFFFD, hi=0xFFFFFFFF, done=1; start reissued at T+10 ignored.
REQ-038 DIVU a=100, b=0 -> T+2: lo=0xFFFFFFFF, hi=100; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle; MTLO during DIV -> lo unchanged.
REQ-040 DIVU started, flush at T+5 -> IDLE at T+6, hi/lo unchanged, no done; same sequence with rst at T+5 -> hi=lo=0, no done.
